fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/pc_register.sv | 25 ++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, canonical NOP, fetch FSM encoding
// and the base opcode map that the fetch unit and the control unit both use.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // ADDI x0,x0,0

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_register.sv
// Program-counter register: synchronous active-high reset to RESET_PC and a
// load enable driven by the fetch unit's consume logic.
module pc_register
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en_i,
  input  logic [XLEN-1:0] pc_d_i,
  output logic [XLEN-1:0] pc_q_o
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q_o <= RESET_PC;
    end else if (load_en_i) begin
      pc_q_o <= pc_d_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/HOLD handshake with instruction memory and
// the next-PC mux. Optional misaligned-target trap under FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSel,
  input  logic [XLEN-1:0] alu_result,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instr_out,
  output logic            instr_valid,
  output logic            misalign
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_next;
  logic            pc_load;
  logic            consume;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load_en_i (pc_load),
    .pc_d_i    (pc_next),
    .pc_q_o    (pc_out)
  );

  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_HOLD);
  assign imem_addr   = pc_out;
  assign pc_plus4    = pc_out + 32'd4;
  assign instr_out   = instr_valid ? instr_q : NOP_INSTR;
  assign consume     = instr_valid & ~stall;
  // Redirect targets only have bit 0 cleared; bit 1 is kept for the trap check.
  assign pc_next     = PCSel ? (alu_result & 32'hFFFF_FFFE) : pc_plus4;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap;
  logic misalign_q;

  assign trap     = PCSel & alu_result[1];
  assign misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (consume && trap) begin
      misalign_q <= 1'b1;
    end
  end
`else
  assign misalign = 1'b0;
`endif

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_load = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (consume) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (trap) begin
            state_d = S_ERR;
          end else
`endif
          begin
            pc_load = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_ERR:   state_d = S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an address scoreboard fed by the PC the
// bench expects and drained whenever the DUT raises imem_req.
module tb_fetch_unit;
  import rv32i_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSel = 1'b0;
  logic [31:0] alu_result = '0;
  logic        stall = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        misalign;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc;
  logic [31:0] held_instr;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .PCSel       (PCSel),
    .alu_result  (alu_result),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b1; PCSel = 1'b0; alu_result = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    cur_pc = RST_PC;
    exp_q.push_back(RST_PC);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_req: imem_req stayed low for 32 cycles");
    end
  endtask

  task automatic serve(input logic [31:0] data, input int waits);
    bit          ok;
    logic [31:0] exp;
    logic [31:0] exp_p4;
    wait_req(ok);
    if (!ok) return;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: request at %h with nothing expected", imem_addr);
      return;
    end
    exp = exp_q.pop_front();
    exp_p4 = exp + 32'd4;
    vectors++;
    if (imem_addr !== exp) begin
      miscompares++;
      $display("FAIL imem_addr: got %h want %h", imem_addr, exp);
    end
    vectors++;
    if (pc_out !== exp) begin
      miscompares++;
      $display("FAIL pc_out_fetch: got %h want %h", pc_out, exp);
    end
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_state: req %b valid %b want 1 0", imem_req, instr_valid);
      end
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    cur_pc = exp;
    held_instr = data;
    vectors++;
    if (instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL instr_valid_hold: got %b want 1", instr_valid);
    end
    vectors++;
    if (instr_out !== data) begin
      miscompares++;
      $display("FAIL instr_out: got %h want %h", instr_out, data);
    end
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL imem_req_hold: got %b want 0", imem_req);
    end
    vectors++;
    if (pc_plus4 !== exp_p4) begin
      miscompares++;
      $display("FAIL pc_plus4: got %h want %h", pc_plus4, exp_p4);
    end
  endtask

  task automatic consume(input bit sel, input logic [31:0] target);
    logic [31:0] nxt;
    nxt = sel ? (target & 32'hFFFF_FFFE) : (cur_pc + 32'd4);
    exp_q.push_back(nxt);
    stall = 1'b0; PCSel = sel; alu_result = target;
    @(negedge clk);
    stall = 1'b1; PCSel = 1'($urandom); alu_result = $urandom;
    vectors++;
    if (instr_valid !== 1'b0 || instr_out !== NOP) begin
      miscompares++;
      $display("FAIL after_consume: valid %b instr %h want 0 %h", instr_valid, instr_out, NOP);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: req %b valid %b mis %b want 0 0 0", imem_req, instr_valid, misalign);
    end
    vectors++;
    if (pc_out !== RST_PC) begin
      miscompares++;
      $display("FAIL reset_pc: got %h want %h", pc_out, RST_PC);
    end
    vectors++;
    if (instr_out !== NOP) begin
      miscompares++;
      $display("FAIL reset_instr: got %h want %h", instr_out, NOP);
    end
  endtask

  task automatic test_first_fetch();
    release_reset();
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_cycle: imem_req got %b want 0", imem_req);
    end
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_cycle2: imem_req got %b want 1", imem_req);
    end
    serve(32'h0050_0093, 0);
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      consume(1'b0, 32'h0);
      serve(32'h0000_0013 + (i << 20), 0);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      PCSel = 1'b1; alu_result = 32'h0000_0800;
      @(negedge clk);
      vectors++;
      if (instr_out !== held_instr || pc_out !== cur_pc || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold: instr %h pc %h req %b valid %b want %h %h 0 1",
                 instr_out, pc_out, imem_req, instr_valid, held_instr, cur_pc);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_redirect();
    consume(1'b1, 32'h0000_0101);
    serve(32'h0000_006F, 0);
    vectors++;
    if (misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_misalign: got %b want 0", misalign);
    end
  endtask

  task automatic test_misalign();
`ifdef FETCH_MISALIGN_TRAP_EN
    logic [31:0] pc_before;
    pc_before = cur_pc;
    stall = 1'b0; PCSel = 1'b1; alu_result = 32'h0000_0102;
    @(negedge clk);
    stall = 1'b1; PCSel = 1'b0;
    vectors++;
    if (misalign !== 1'b1 || pc_out !== pc_before) begin
      miscompares++;
      $display("FAIL trap_entry: mis %b pc %h want 1 %h", misalign, pc_out, pc_before);
    end
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1; stall = 1'(i & 1);
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign !== 1'b1) begin
        miscompares++;
        $display("FAIL trap_hold: req %b valid %b mis %b want 0 0 1", imem_req, instr_valid, misalign);
      end
    end
    do_reset();
    vectors++;
    if (misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL trap_reset: misalign got %b want 0", misalign);
    end
    release_reset();
    serve(32'h0000_0013, 1);
`else
    consume(1'b1, 32'h0000_0102);
    serve(32'h0000_0013, 1);
    vectors++;
    if (misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_tied: got %b want 0", misalign);
    end
`endif
  endtask

  task automatic test_reset_during_ack();
    bit ok;
    consume(1'b1, 32'h0000_0040);
    wait_req(ok);
    vectors++;
    if (pc_out !== 32'h0000_0040) begin
      miscompares++;
      $display("FAIL pre_reset_pc: got %h want 00000040", pc_out);
    end
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_BABE;
    exp_q.delete();
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0 || instr_out !== NOP || pc_out !== RST_PC || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_vs_ack: valid %b instr %h pc %h req %b want 0 %h %h 0",
               instr_valid, instr_out, pc_out, imem_req, NOP, RST_PC);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    release_reset();
    serve(32'h0010_0113, 2);
  endtask

  task automatic test_wrap();
    consume(1'b1, 32'hFFFF_FFFC);
    serve(32'h0000_0013, 0);
    vectors++;
    if (pc_plus4 !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL wrap_plus4: got %h want 00000000", pc_plus4);
    end
    consume(1'b0, 32'h0);
    serve(32'h0020_0193, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] tgt;
    for (int i = 0; i < 8; i++) begin
      tgt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt[1] = 1'b0;
`endif
      consume(1'($urandom), tgt);
      serve($urandom, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; stall = 1'b0; PCSel = 1'b1; alu_result = 32'h0000_0080;
    @(negedge clk);
    vectors++;
    if (pc_out !== RST_PC || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_priority: pc %h valid %b want %h 0", pc_out, instr_valid, RST_PC);
    end
    stall = 1'b1; PCSel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_stall();
    test_redirect();
    test_misalign();
    test_reset_during_ack();
    test_wrap();
    test_back_to_back();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
